alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the per-bit 8-way result multiplexers.
- Captures the WIDTH-bit selected ALU result together with the opcode and the adder carry/overflow, and computes the zero and negative flags.
- Presents the result to the consumer over a valid/ready handshake through a 2-entry skid buffer, so the ALU front end never sees a combinational ready path.
- Keeps a sticky overflow flag and a transfer counter for status readback.

Parameters:
- WIDTH, 32, result width; one mux8way slice per bit upstream.
- COUNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept.
- in_result  in  WIDTH  result bus, bit i from mux slice i.
- in_op  in  3  opcode, the same 3-bit select that drove the muxes.
- in_carry  in  1  adder carry out.
- in_ovf  in  1  adder signed overflow.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  registered result.
- out_op  out  3  registered opcode.
- out_zero  out  1  result == 0.
- out_neg  out  1  result[WIDTH-1].
- out_carry  out  1  masked carry.
- out_ovf  out  1  masked overflow.
- clr_sticky  in  1  clears sticky_ovf.
- sticky_ovf  out  1  set once any overflowing entry has transferred out.
- xfer_count  out  COUNT_W  number of output transfers, wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state EMPTY; main and skid entries cleared.
  - out_valid, out_result, out_op, out_zero, out_neg, out_carry, out_ovf, sticky_ovf, xfer_count all = 0.
  - in_ready = 1.
- Reset mid-operation discards both entries with no output transfer.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Flags are computed when an entry is captured and stored with it:
  - zero = (in_result == 0).
  - neg = in_result[WIDTH-1].
  - carry and ovf pass through only when in_op is OP_ADD or OP_SUB; otherwise they are forced to 0.
- The out_* data ports always reflect the main entry. Their values are don't-care-stable (held) when out_valid = 0.
- State machine, registered, three states; in_ready = (state != TWO); out_valid = (state != EMPTY):
  - EMPTY: in_fire -> load main, go ONE.
  - ONE, in_fire and !out_fire: load skid, go TWO.
  - ONE, in_fire and out_fire: load main from input, stay ONE.
  - ONE, !in_fire and out_fire: go EMPTY.
  - ONE, neither: hold.
  - TWO, out_fire: main <= skid, go ONE.
  - TWO, no out_fire: hold. in_valid is ignored because in_ready = 0.
- Latency: an input accepted at edge N is visible on out_* after edge N, so out_valid is high in cycle N+1 when the stage was empty.
- Ordering: strict FIFO. Every accepted input is output exactly once; nothing is dropped or duplicated.
- Full throughput: with out_ready held high, one transfer per cycle and the state stays ONE.
- out_valid is never withdrawn and out_* never change while out_valid = 1 and out_ready = 0.
- sticky_ovf:
  - set on out_fire with out_ovf = 1.
  - cleared by clr_sticky.
  - if set and clear occur in the same cycle, set wins.
- xfer_count increments on each out_fire and wraps from 2^COUNT_W-1 to 0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams OP_ADD=3'd0, OP_SUB=3'd1, OP_XOR=3'd2, OP_SLT=3'd3, OP_AND=3'd4, OP_NAND=3'd5, OP_NOR=3'd6, OP_OR=3'd7.
  - the state encodings EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- One sub-module, alu_flag_gen: combinational; takes result and op and produces zero, neg and the masked carry/ovf. It is instanced once at the stage input, and its outputs are captured with the entry.
- The skid control, the entry registers and the counters live in alu_result_stage.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n low.
  - Required: out_valid=0, in_ready=1, xfer_count=0, sticky_ovf=0.
  - Stimulus: release reset.
  - Required: the same values hold with no input.
- Single ADD:
  - Stimulus: in_result=32'h0, in_op=OP_ADD, in_carry=1, in_ovf=0, one-cycle in_valid, out_ready=1.
  - Required: next cycle out_valid=1, out_zero=1, out_carry=1, out_neg=0; xfer_count becomes 1.
- Masking:
  - Stimulus: in_op=OP_AND, in_result=32'h8000_0000, in_carry=1, in_ovf=1.
  - Required: out_neg=1, out_carry=0, out_ovf=0, sticky_ovf stays 0.
- Backpressure:
  - Stimulus: out_ready=0; push A=1, B=2, C=3 on consecutive cycles.
  - Required: A and B are accepted; in_ready drops after B so C is stalled; out_result holds 1.
  - Stimulus: raise out_ready.
  - Required: outputs appear in order 1, 2, 3 with no loss; xfer_count=3.
- Sticky and counter:
  - Stimulus: an OP_SUB entry with in_ovf=1 transfers out while clr_sticky is pulsed in the same cycle.
  - Required: sticky_ovf=1.
  - Stimulus: pulse clr_sticky alone.
  - Required: sticky_ovf=0.
  - Stimulus: with COUNT_W=4, perform 17 transfers.
  - Required: xfer_count=1.
- Reset mid-operation:
  - Stimulus: get the stage to state TWO, then assert rst_n low asynchronously mid-cycle.
  - Required: out_valid falls immediately; after release, no stale entry is ever output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, result-stage state encodings and
// the flag bundle captured alongside each result entry.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

  // Carry/overflow are only meaningful for the adder opcodes.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for one ALU result.
// Ports: result/op/carry/ovf in; flags (zero, neg, masked carry, masked ovf) out.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic [2:0]       op,
  input  logic             carry,
  input  logic             ovf,
  output flags_t           flags
);

  always_comb begin
    flags       = '0;
    flags.zero  = (result == '0);
    flags.neg   = result[WIDTH-1];
    flags.carry = carry & is_arith(op);
    flags.ovf   = ovf & is_arith(op);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures result, opcode and flags into a
// 2-entry skid buffer and presents them over valid/ready. Also keeps a sticky
// overflow flag and a wrapping transfer counter.
// Ports: in_valid/in_ready/in_result/in_op/in_carry/in_ovf (upstream),
//        out_valid/out_ready/out_result/out_op/out_zero/out_neg/out_carry/
//        out_ovf (downstream), clr_sticky/sticky_ovf/xfer_count (status).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic [2:0]         in_op,
  input  logic               in_carry,
  input  logic               in_ovf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2:0]         out_op,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_carry,
  output logic               out_ovf,
  input  logic               clr_sticky,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] xfer_count
);

  logic [1:0]         state_q, state_d;
  logic               in_ready_q, out_valid_q;
  logic [WIDTH-1:0]   main_res_q, skid_res_q;
  logic [2:0]         main_op_q, skid_op_q;
  flags_t             main_flags_q, skid_flags_q;
  flags_t             in_flags;
  logic               sticky_q;
  logic [COUNT_W-1:0] count_q;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Flags are computed once at the input and travel with the entry.
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .op     (in_op),
    .carry  (in_carry),
    .ovf    (in_ovf),
    .flags  (in_flags)
  );

  // Skid-buffer next-state and entry-load decode.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State plus handshake flags registered from next state, so neither
  // ready nor valid has a combinational path from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_res_q   <= '0;
      main_op_q    <= '0;
      main_flags_q <= '0;
      skid_res_q   <= '0;
      skid_op_q    <= '0;
      skid_flags_q <= '0;
    end else begin
      if (load_main_in) begin
        main_res_q   <= in_result;
        main_op_q    <= in_op;
        main_flags_q <= in_flags;
      end else if (load_main_skid) begin
        main_res_q   <= skid_res_q;
        main_op_q    <= skid_op_q;
        main_flags_q <= skid_flags_q;
      end
      if (load_skid) begin
        skid_res_q   <= in_result;
        skid_op_q    <= in_op;
        skid_flags_q <= in_flags;
      end
    end
  end

  // Status: sticky overflow (set beats clear) and wrapping transfer count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (out_fire && main_flags_q.ovf) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
      if (out_fire) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = main_res_q;
  assign out_op     = main_op_q;
  assign out_zero   = main_flags_q.zero;
  assign out_neg    = main_flags_q.neg;
  assign out_carry  = main_flags_q.carry;
  assign out_ovf    = main_flags_q.ovf;
  assign sticky_ovf = sticky_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (WIDTH=32, COUNT_W=4).
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_result;
  logic [2:0]         in_op;
  logic               in_carry;
  logic               in_ovf;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic [2:0]         out_op;
  logic               out_zero;
  logic               out_neg;
  logic               out_carry;
  logic               out_ovf;
  logic               clr_sticky;
  logic               sticky_ovf;
  logic [COUNT_W-1:0] xfer_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .in_carry   (in_carry),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .xfer_count (xfer_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_result  = '0;
    in_op      = OP_ADD;
    in_carry   = 1'b0;
    in_ovf     = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;

    // Reset and idle
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_xfer", 64'(xfer_count), 64'd0);
    check("rst_sticky", 64'(sticky_ovf), 64'd0);
    rst_n = 1'b1;
    cyc(); cyc();
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_xfer", 64'(xfer_count), 64'd0);

    // Single ADD of zero with carry
    in_valid = 1'b1; in_result = 32'h0; in_op = OP_ADD; in_carry = 1'b1; in_ovf = 1'b0;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_zero", 64'(out_zero), 64'd1);
    check("add_carry", 64'(out_carry), 64'd1);
    check("add_neg", 64'(out_neg), 64'd0);
    check("add_op", 64'(out_op), 64'(OP_ADD));
    cyc();
    check("add_xfer", 64'(xfer_count), 64'd1);
    check("add_drained", 64'(out_valid), 64'd0);

    // Non-arith op masks carry/ovf
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h8000_0000; in_op = OP_AND; in_carry = 1'b1; in_ovf = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("mask_neg", 64'(out_neg), 64'd1);
    check("mask_zero", 64'(out_zero), 64'd0);
    check("mask_carry", 64'(out_carry), 64'd0);
    check("mask_ovf", 64'(out_ovf), 64'd0);
    out_ready = 1'b1;
    cyc();
    check("mask_sticky", 64'(sticky_ovf), 64'd0);
    check("mask_xfer", 64'(xfer_count), 64'd2);

    // Backpressure: A=1, B=2 fill the buffer, C=3 stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_XOR; in_carry = 1'b0; in_ovf = 1'b0;
    in_result = 32'd1;
    cyc();
    check("bp_a_ready", 64'(in_ready), 64'd1);
    in_result = 32'd2;
    cyc();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(out_result), 64'd1);
    in_result = 32'd3;
    cyc();
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_valid", 64'(out_valid), 64'd1);
    check("bp_stall_hold", 64'(out_result), 64'd1);
    out_ready = 1'b1;
    cyc();
    check("bp_out_b", 64'(out_result), 64'd2);
    cyc();
    in_valid = 1'b0;
    check("bp_out_c", 64'(out_result), 64'd3);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    cyc();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_xfer", 64'(xfer_count), 64'd5);

    // Sticky overflow: set wins over simultaneous clear
    in_valid = 1'b1; in_op = OP_SUB; in_result = 32'd5; in_ovf = 1'b1;
    cyc();
    in_valid = 1'b0; in_ovf = 1'b0;
    check("sub_ovf", 64'(out_ovf), 64'd1);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    check("sticky_xfer", 64'(xfer_count), 64'd6);
    cyc();
    check("sticky_holds", 64'(sticky_ovf), 64'd1);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check("sticky_clr", 64'(sticky_ovf), 64'd0);

    // 17 streamed transfers at full rate; 4-bit counter wraps 6+17 -> 7
    in_op = OP_OR;
    for (int i = 0; i < 17; i++) begin
      in_valid  = 1'b1;
      in_result = 32'(i + 16);
      cyc();
      check("stream_ready", 64'(in_ready), 64'd1);
      check("stream_data", 64'(out_result), 64'(i + 16));
    end
    in_valid = 1'b0;
    cyc();
    check("wrap_xfer", 64'(xfer_count), 64'd7);
    check("wrap_drained", 64'(out_valid), 64'd0);

    // Reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_XOR;
    in_result = 32'hAA;
    cyc();
    in_result = 32'hBB;
    cyc();
    in_valid = 1'b0;
    check("mid_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_xfer", 64'(xfer_count), 64'd0);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end
    check("mid_no_xfer", 64'(xfer_count), 64'd0);
    in_valid = 1'b1; in_result = 32'hCC;
    cyc();
    in_valid = 1'b0;
    check("post_rst_data", 64'(out_result), 64'hCC);
    cyc();
    check("post_rst_xfer", 64'(xfer_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
